wb_port_arbiter: RTL and testbench

Write-back arbiter for the 4-way superscalar core. Up to three result sources (ALU slot 1, ALU slot 2, load slot) can complete in the same cycle, but the register file has only two write ports. The block grants up to two writes per cycle in program order and parks the excess in a small in-order pending buffer. It raises a stall to the front end before that buffer can overflow, and offers a lookup port so the hazard unit can forward values that are still pending.

---
 rtl/wb_port_arbiter_if.sv | 34 +++
 rtl/wb_port_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_wb_port_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_port_arbiter_if.sv
// Bus bundle for wb_port_arbiter: three write-back result sources,
// two register-file write ports, flow control, and the hazard lookup port.
interface wb_port_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             Req1, Req2, Req3;
  logic [4:0]       Addr1, Addr2, Addr3;
  logic [WIDTH-1:0] Data1, Data2, Data3;

  logic             WE1, WE2;
  logic [4:0]       Aw1, Aw2;
  logic [WIDTH-1:0] WD1, WD2;

  logic             Stall;
  logic [CW-1:0]    PendCount;
  logic             Overflow;

  logic [4:0]       LookupAddr;
  logic             LookupHit;
  logic [WIDTH-1:0] LookupData;

  modport master (
    output Req1, Req2, Req3, Addr1, Addr2, Addr3, Data1, Data2, Data3, LookupAddr,
    input  WE1, WE2, Aw1, Aw2, WD1, WD2, Stall, PendCount, Overflow, LookupHit, LookupData
  );

  modport slave (
    input  Req1, Req2, Req3, Addr1, Addr2, Addr3, Data1, Data2, Data3, LookupAddr,
    output WE1, WE2, Aw1, Aw2, WD1, WD2, Stall, PendCount, Overflow, LookupHit, LookupData
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Write-back arbiter: grants up to two register-file writes per cycle in
// program order (pending entries first, then Req1..Req3), parks the rest in
// an in-order pending buffer, and raises Stall before the buffer can fill.
// Optional feature macro: WB_ARB_LOOKUP_EN builds the pending-entry lookup
// search; without it LookupHit and LookupData are tied to 0.
module wb_port_arbiter #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input logic             CLK,
  input logic             CLR,
  wb_port_arbiter_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int XW = CW + 1;

  logic [4:0]       addr_mem [DEPTH];
  logic [WIDTH-1:0] data_mem [DEPTH];
  logic [PW-1:0]    rptr, wptr;
  logic [CW-1:0]    count, count_next;
  logic             stall_q, overflow_q, overflow_set;

  logic [4:0]       req_addr [3];
  logic [WIDTH-1:0] req_data [3];
  logic [2:0]       req_valid;
  logic [4:0]       new_addr [4];
  logic [WIDTH-1:0] new_data [4];
  logic [4:0]       push_addr [4];
  logic [WIDTH-1:0] push_data [4];
  logic [1:0]       new_num, pend_grant, avail, new_grant, push_num, push_ok;
  logic [XW-1:0]    free_slots;
  logic [PW-1:0]    rptr_1;

  logic             we1, we2;
  logic [4:0]       aw1, aw2;
  logic [WIDTH-1:0] wd1, wd2;

  assign req_addr[0] = bus.Addr1;
  assign req_addr[1] = bus.Addr2;
  assign req_addr[2] = bus.Addr3;
  assign req_data[0] = bus.Data1;
  assign req_data[1] = bus.Data2;
  assign req_data[2] = bus.Data3;
  assign req_valid   = {bus.Req3, bus.Req2, bus.Req1};
  assign rptr_1      = rptr + PW'(1);

  // Compact the usable new requests (register 0 dropped) into program order.
  always_comb begin
    new_num = 2'd0;
    for (int i = 0; i < 4; i++) begin
      new_addr[i] = '0;
      new_data[i] = '0;
    end
    for (int i = 0; i < 3; i++) begin
      if (req_valid[i] && req_addr[i] != 5'd0) begin
        new_addr[new_num] = req_addr[i];
        new_data[new_num] = req_data[i];
        new_num = new_num + 2'd1;
      end
    end
  end

  // Decide how many pending and new candidates are granted, and how many new ones get buffered.
  always_comb begin
    pend_grant   = (count >= CW'(2)) ? 2'd2 : count[1:0];
    avail        = 2'd2 - pend_grant;
    new_grant    = (new_num < avail) ? new_num : avail;
    push_num     = new_num - new_grant;
    free_slots   = XW'(DEPTH) - XW'(count) + XW'(pend_grant);
    overflow_set = 1'b0;
    push_ok      = push_num;
    if (XW'(push_num) > free_slots) begin
      push_ok      = free_slots[1:0];
      overflow_set = 1'b1;
    end
    count_next = CW'(XW'(count) - XW'(pend_grant) + XW'(push_ok));
    for (int i = 0; i < 4; i++) begin
      push_addr[i] = '0;
      push_data[i] = '0;
    end
    case (new_grant)
      2'd0: begin
        for (int i = 0; i < 3; i++) begin
          push_addr[i] = new_addr[i];
          push_data[i] = new_data[i];
        end
      end
      2'd1: begin
        push_addr[0] = new_addr[1];
        push_data[0] = new_data[1];
        push_addr[1] = new_addr[2];
        push_data[1] = new_data[2];
      end
      default: begin
        push_addr[0] = new_addr[2];
        push_data[0] = new_data[2];
      end
    endcase
  end

  // Pick the two oldest candidates for the write ports; same-address pairs keep only the younger write.
  always_comb begin
    we1 = 1'b0;
    aw1 = '0;
    wd1 = '0;
    we2 = 1'b0;
    aw2 = '0;
    wd2 = '0;
    if (count != '0) begin
      we1 = 1'b1;
      aw1 = addr_mem[rptr];
      wd1 = data_mem[rptr];
    end else if (new_num != 2'd0) begin
      we1 = 1'b1;
      aw1 = new_addr[0];
      wd1 = new_data[0];
    end
    if (count >= CW'(2)) begin
      we2 = 1'b1;
      aw2 = addr_mem[rptr_1];
      wd2 = data_mem[rptr_1];
    end else if (count == CW'(1) && new_num != 2'd0) begin
      we2 = 1'b1;
      aw2 = new_addr[0];
      wd2 = new_data[0];
    end else if (count == '0 && new_num >= 2'd2) begin
      we2 = 1'b1;
      aw2 = new_addr[1];
      wd2 = new_data[1];
    end
    if (we1 && we2 && aw1 == aw2) begin
      we1 = 1'b0;
    end
  end

  // Occupancy, pointers, stall and sticky overflow; reset throws away all pending writes.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      rptr       <= '0;
      wptr       <= '0;
      count      <= '0;
      stall_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      rptr       <= rptr + PW'(pend_grant);
      wptr       <= wptr + PW'(push_ok);
      count      <= count_next;
      stall_q    <= (count_next >= CW'(DEPTH - 1));
      overflow_q <= overflow_q | overflow_set;
    end
  end

  // Buffer storage is never cleared; only the pointers and count decide what is valid.
  always_ff @(posedge CLK) begin
    for (int k = 0; k < 3; k++) begin
      if (2'(k) < push_ok) begin
        addr_mem[wptr + PW'(k)] <= push_addr[k];
        data_mem[wptr + PW'(k)] <= push_data[k];
      end
    end
  end

`ifdef WB_ARB_LOOKUP_EN
  logic             hit;
  logic [WIDTH-1:0] hit_data;

  // Scan oldest to youngest so the last match found is the youngest one.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    if (bus.LookupAddr != 5'd0) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CW'(i) < count && addr_mem[rptr + PW'(i)] == bus.LookupAddr) begin
          hit      = 1'b1;
          hit_data = data_mem[rptr + PW'(i)];
        end
      end
    end
  end

  assign bus.LookupHit  = hit;
  assign bus.LookupData = hit_data;
`else
  assign bus.LookupHit  = 1'b0;
  assign bus.LookupData = '0;
`endif

  assign bus.WE1       = we1;
  assign bus.Aw1       = aw1;
  assign bus.WD1       = wd1;
  assign bus.WE2       = we2;
  assign bus.Aw2       = aw2;
  assign bus.WD2       = wd2;
  assign bus.Stall     = stall_q;
  assign bus.PendCount = count;
  assign bus.Overflow  = overflow_q;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Testbench for wb_port_arbiter: directed scenarios plus a randomized run
// checked against a queue-based model of the write-back rules.
module tb_wb_port_arbiter;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [4:0]       addr;
    logic [WIDTH-1:0] data;
  } entry_t;

  logic CLK;
  logic CLR;
  int   checks;
  int   failures;

  wb_port_arbiter_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  wb_port_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK(CLK),
    .CLR(CLR),
    .bus(bus)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  entry_t           pend_q[$];
  entry_t           new_q[$];
  logic             model_stall, model_ovf;
  logic             exp_we1, exp_we2, exp_collapse, exp_hit;
  logic [4:0]       exp_aw1, exp_aw2;
  logic [WIDTH-1:0] exp_wd1, exp_wd2, exp_hdata;

  task automatic set_inputs(input logic r1, input logic [4:0] a1, input logic [WIDTH-1:0] d1,
                            input logic r2, input logic [4:0] a2, input logic [WIDTH-1:0] d2,
                            input logic r3, input logic [4:0] a3, input logic [WIDTH-1:0] d3,
                            input logic [4:0] la);
    bus.Req1 = r1; bus.Addr1 = a1; bus.Data1 = d1;
    bus.Req2 = r2; bus.Addr2 = a2; bus.Data2 = d2;
    bus.Req3 = r3; bus.Addr3 = a3; bus.Data3 = d3;
    bus.LookupAddr = la;
  endtask

  task automatic set_idle();
    set_inputs(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic model_reset();
    pend_q.delete();
    model_stall = 1'b0;
    model_ovf   = 1'b0;
  endtask

  // Expected combinational outputs for the current inputs and model state.
  task automatic eval_model();
    entry_t cand[$];
    new_q.delete();
    if (bus.Req1 && bus.Addr1 != 0) new_q.push_back({bus.Addr1, bus.Data1});
    if (bus.Req2 && bus.Addr2 != 0) new_q.push_back({bus.Addr2, bus.Data2});
    if (bus.Req3 && bus.Addr3 != 0) new_q.push_back({bus.Addr3, bus.Data3});
    cand = pend_q;
    foreach (new_q[i]) cand.push_back(new_q[i]);
    exp_we1 = 0; exp_aw1 = 0; exp_wd1 = 0;
    exp_we2 = 0; exp_aw2 = 0; exp_wd2 = 0;
    exp_collapse = 0;
    if (cand.size() >= 1) begin
      exp_we1 = 1; exp_aw1 = cand[0].addr; exp_wd1 = cand[0].data;
    end
    if (cand.size() >= 2) begin
      exp_we2 = 1; exp_aw2 = cand[1].addr; exp_wd2 = cand[1].data;
      if (cand[0].addr == cand[1].addr) begin
        exp_we1 = 0;
        exp_collapse = 1;
      end
    end
    exp_hit = 0;
    exp_hdata = 0;
`ifdef WB_ARB_LOOKUP_EN
    if (bus.LookupAddr != 0) begin
      foreach (pend_q[i]) begin
        if (pend_q[i].addr == bus.LookupAddr) begin
          exp_hit = 1;
          exp_hdata = pend_q[i].data;
        end
      end
    end
`endif
  endtask

  // Clock edge: retire up to two oldest candidates, buffer the rest, drop what does not fit.
  task automatic advance();
    int pops;
    int granted_new;
    @(posedge CLK);
    pops = (pend_q.size() < 2) ? pend_q.size() : 2;
    granted_new = 2 - pops;
    for (int i = 0; i < pops; i++) void'(pend_q.pop_front());
    for (int i = granted_new; i < new_q.size(); i++) begin
      if (pend_q.size() < DEPTH) pend_q.push_back(new_q[i]);
      else model_ovf = 1'b1;
    end
    model_stall = (pend_q.size() >= DEPTH - 1);
    #1;
  endtask

  task automatic do_reset();
    set_idle();
    CLR = 1'b1;
    @(posedge CLK);
    #1;
    CLR = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge CLK);
    checks++;
    if (bus.PendCount !== CW'(0) || bus.Stall !== 1'b0 || bus.Overflow !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_state: count/stall/ovf=%0d/%b/%b required 0/0/0",
               bus.PendCount, bus.Stall, bus.Overflow);
    end
    checks++;
    if ({bus.WE1, bus.Aw1, bus.WD1, bus.WE2, bus.Aw2, bus.WD2} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_ports: WE1=%b Aw1=%0d WD1=%h WE2=%b Aw2=%0d WD2=%h required all 0",
               bus.WE1, bus.Aw1, bus.WD1, bus.WE2, bus.Aw2, bus.WD2);
    end
    advance();
  endtask

  task automatic test_two_requests();
    do_reset();
    set_inputs(1, 3, 32'h11, 1, 4, 32'h22, 0, 0, 0, 0);
    @(negedge CLK);
    checks++;
    if ({bus.WE1, bus.Aw1, bus.WD1} !== {1'b1, 5'd3, 32'h11}) begin
      failures++;
      $display("[TB] FAIL two_req_port1: WE1=%b Aw1=%0d WD1=%h required 1/3/11", bus.WE1, bus.Aw1, bus.WD1);
    end
    checks++;
    if ({bus.WE2, bus.Aw2, bus.WD2} !== {1'b1, 5'd4, 32'h22}) begin
      failures++;
      $display("[TB] FAIL two_req_port2: WE2=%b Aw2=%0d WD2=%h required 1/4/22", bus.WE2, bus.Aw2, bus.WD2);
    end
    eval_model();
    advance();
    set_idle();
    checks++;
    if (bus.PendCount !== CW'(0)) begin
      failures++;
      $display("[TB] FAIL two_req_count: PendCount=%0d required 0", bus.PendCount);
    end
  endtask

  task automatic test_three_requests();
    logic             h;
    logic [WIDTH-1:0] hd;
    do_reset();
    set_inputs(1, 1, 32'hA, 1, 2, 32'hB, 1, 5, 32'hC, 0);
    @(negedge CLK);
    checks++;
    if ({bus.WE1, bus.Aw1, bus.WD1, bus.WE2, bus.Aw2, bus.WD2} !== {1'b1, 5'd1, 32'hA, 1'b1, 5'd2, 32'hB}) begin
      failures++;
      $display("[TB] FAIL three_req_c0: Aw1=%0d WD1=%h Aw2=%0d WD2=%h required 1/A 2/B",
               bus.Aw1, bus.WD1, bus.Aw2, bus.WD2);
    end
    eval_model();
    advance();
    set_inputs(0, 0, 0, 0, 0, 0, 0, 0, 0, 5);
    @(negedge CLK);
    checks++;
    if (bus.PendCount !== CW'(1)) begin
      failures++;
      $display("[TB] FAIL three_req_count1: PendCount=%0d required 1", bus.PendCount);
    end
`ifdef WB_ARB_LOOKUP_EN
    h = 1'b1; hd = 32'hC;
`else
    h = 1'b0; hd = '0;
`endif
    checks++;
    if (bus.LookupHit !== h || bus.LookupData !== hd) begin
      failures++;
      $display("[TB] FAIL three_req_lookup: hit=%b data=%h required %b/%h", bus.LookupHit, bus.LookupData, h, hd);
    end
    checks++;
    if ({bus.WE1, bus.Aw1, bus.WD1, bus.WE2} !== {1'b1, 5'd5, 32'hC, 1'b0}) begin
      failures++;
      $display("[TB] FAIL three_req_c1: WE1=%b Aw1=%0d WD1=%h WE2=%b required 1/5/C/0",
               bus.WE1, bus.Aw1, bus.WD1, bus.WE2);
    end
    eval_model();
    advance();
    set_idle();
    checks++;
    if (bus.PendCount !== CW'(0)) begin
      failures++;
      $display("[TB] FAIL three_req_count2: PendCount=%0d required 0", bus.PendCount);
    end
  endtask

  task automatic test_collapse();
    do_reset();
    set_inputs(1, 10, 32'h5, 1, 11, 32'h6, 1, 7, 32'h1, 0);
    @(negedge CLK);
    eval_model();
    advance();
    set_inputs(1, 7, 32'h2, 0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    checks++;
    if (bus.WE1 !== 1'b0 || {bus.WE2, bus.Aw2, bus.WD2} !== {1'b1, 5'd7, 32'h2}) begin
      failures++;
      $display("[TB] FAIL collapse: WE1=%b WE2=%b Aw2=%0d WD2=%h required 0/1/7/2",
               bus.WE1, bus.WE2, bus.Aw2, bus.WD2);
    end
    eval_model();
    advance();
    set_idle();
    checks++;
    if (bus.PendCount !== CW'(0)) begin
      failures++;
      $display("[TB] FAIL collapse_count: PendCount=%0d required 0", bus.PendCount);
    end
  endtask

  task automatic test_addr_zero();
    do_reset();
    set_inputs(1, 9, 32'h99, 0, 0, 0, 1, 0, 32'h77, 0);
    @(negedge CLK);
    checks++;
    if ({bus.WE1, bus.Aw1, bus.WD1, bus.WE2, bus.Aw2, bus.WD2} !== {1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'h0}) begin
      failures++;
      $display("[TB] FAIL addr_zero: WE1=%b Aw1=%0d WD1=%h WE2=%b Aw2=%0d WD2=%h required 1/9/99/0/0/0",
               bus.WE1, bus.Aw1, bus.WD1, bus.WE2, bus.Aw2, bus.WD2);
    end
    eval_model();
    advance();
    set_idle();
    checks++;
    if (bus.PendCount !== CW'(0)) begin
      failures++;
      $display("[TB] FAIL addr_zero_count: PendCount=%0d required 0", bus.PendCount);
    end
  endtask

  task automatic test_stall_overflow();
    int exp_cnt[5]  = '{1, 2, 3, 4, 4};
    int exp_stl[5]  = '{0, 0, 1, 1, 1};
    int exp_ovf[5]  = '{0, 0, 0, 0, 1};
    do_reset();
    for (int c = 0; c < 5; c++) begin
      set_inputs(1, 5'(3 * c + 1), 32'(c), 1, 5'(3 * c + 2), 32'(c + 16), 1, 5'(3 * c + 3), 32'(c + 32), 0);
      @(negedge CLK);
      eval_model();
      advance();
      checks++;
      if (int'(bus.PendCount) != exp_cnt[c] || int'(bus.Stall) != exp_stl[c] || int'(bus.Overflow) != exp_ovf[c]) begin
        failures++;
        $display("[TB] FAIL stall_ovf_c%0d: count/stall/ovf=%0d/%b/%b required %0d/%0d/%0d",
                 c, bus.PendCount, bus.Stall, bus.Overflow, exp_cnt[c], exp_stl[c], exp_ovf[c]);
      end
    end
    set_idle();
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      eval_model();
      advance();
    end
    checks++;
    if (bus.Overflow !== 1'b1 || bus.PendCount !== CW'(0) || bus.Stall !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ovf_sticky: ovf=%b count=%0d stall=%b required 1/0/0", bus.Overflow, bus.PendCount, bus.Stall);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      set_inputs(1, 5'(c + 1), 32'(c), 1, 5'(c + 8), 32'(c), 1, 5'(c + 16), 32'(c), 0);
      @(negedge CLK);
      eval_model();
      advance();
    end
    set_idle();
    checks++;
    if (bus.PendCount !== CW'(3) || bus.Stall !== 1'b1) begin
      failures++;
      $display("[TB] FAIL mid_pre: count=%0d stall=%b required 3/1", bus.PendCount, bus.Stall);
    end
    #2;
    CLR = 1'b1;
    #1;
    checks++;
    if (bus.PendCount !== CW'(0) || bus.Stall !== 1'b0 || bus.Overflow !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mid_reset: count/stall/ovf=%0d/%b/%b required 0/0/0", bus.PendCount, bus.Stall, bus.Overflow);
    end
    @(posedge CLK);
    #1;
    CLR = 1'b0;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      checks++;
      if (bus.WE1 !== 1'b0 || bus.WE2 !== 1'b0) begin
        failures++;
        $display("[TB] FAIL mid_no_write_c%0d: WE1=%b WE2=%b required 0/0", c, bus.WE1, bus.WE2);
      end
      eval_model();
      advance();
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      logic go;
      go = !model_stall && ($urandom_range(0, 3) != 0);
      set_inputs(go && $urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
                 go && $urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
                 go && $urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
                 5'($urandom_range(0, 7)));
      @(negedge CLK);
      eval_model();
      checks++;
      if (bus.WE1 !== exp_we1 || (!exp_collapse && (bus.Aw1 !== exp_aw1 || bus.WD1 !== exp_wd1))) begin
        failures++;
        $display("[TB] FAIL rand_port1 n=%0d: WE1=%b Aw1=%0d WD1=%h required %b/%0d/%h",
                 n, bus.WE1, bus.Aw1, bus.WD1, exp_we1, exp_aw1, exp_wd1);
      end
      checks++;
      if ({bus.WE2, bus.Aw2, bus.WD2} !== {exp_we2, exp_aw2, exp_wd2}) begin
        failures++;
        $display("[TB] FAIL rand_port2 n=%0d: WE2=%b Aw2=%0d WD2=%h required %b/%0d/%h",
                 n, bus.WE2, bus.Aw2, bus.WD2, exp_we2, exp_aw2, exp_wd2);
      end
      checks++;
      if (int'(bus.PendCount) != pend_q.size() || bus.Stall !== model_stall || bus.Overflow !== model_ovf) begin
        failures++;
        $display("[TB] FAIL rand_state n=%0d: count/stall/ovf=%0d/%b/%b required %0d/%b/%b",
                 n, bus.PendCount, bus.Stall, bus.Overflow, pend_q.size(), model_stall, model_ovf);
      end
      checks++;
      if (bus.LookupHit !== exp_hit || bus.LookupData !== exp_hdata) begin
        failures++;
        $display("[TB] FAIL rand_lookup n=%0d: hit=%b data=%h required %b/%h",
                 n, bus.LookupHit, bus.LookupData, exp_hit, exp_hdata);
      end
      advance();
    end
  endtask

  // Run every scenario in turn, then report.
  initial begin
    checks   = 0;
    failures = 0;
    CLR      = 1'b1;
    set_idle();
    model_reset();
    #1;
    test_reset();
    test_two_requests();
    test_three_requests();
    test_collapse();
    test_addr_zero();
    test_stall_overflow();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
